// File: rtl/csr_trap_unit.sv
// User-mode CSR file and trap controller: CSRRW/RS/RC access, trap entry/URET,
// registered interrupt pending/enable with vectored targets, 64-bit counters.
module csr_trap_unit #(
    parameter int               XLEN        = 32,
    parameter int               TIME_DIV    = 50,
    parameter logic [XLEN-1:0]  UTVEC_RESET = '0
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic [1:0]      iCsrOp,
    input  logic [11:0]     iCsrAddr,
    input  logic [XLEN-1:0] iWriteData,
    input  logic            iNoWrite,
    output logic [XLEN-1:0] oReadData,
    output logic            oIllegal,
    input  logic            iTrap,
    input  logic [XLEN-1:0] iCause,
    input  logic [XLEN-1:0] iEpc,
    input  logic [XLEN-1:0] iTval,
    input  logic            iUret,
    output logic [XLEN-1:0] oTrapPC,
    output logic [XLEN-1:0] oEpc,
    input  logic            iIrqExt,
    input  logic            iIrqTimer,
    input  logic            iIrqSoft,
    output logic            oIrqReq,
    output logic [XLEN-1:0] oIrqCause,
    input  logic            iRetire,
    input  logic [11:0]     iDispSelect,
    output logic [XLEN-1:0] oDispData
);

    localparam int              PW        = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
    localparam logic [XLEN-1:0] UIE_MASK  = XLEN'(12'h111);
    localparam logic [XLEN-1:0] EPC_MASK  = ~XLEN'(2'b11);
    localparam logic [XLEN-1:0] IRQ_FLAG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    typedef struct packed {
        logic            hit;
        logic            ro;
        logic [XLEN-1:0] data;
    } csr_rd_t;

    logic            uie_bit_q, uie_bit_d;
    logic            upie_q, upie_d;
    logic [4:0]      fflags_q, fflags_d;
    logic [2:0]      frm_q, frm_d;
    logic [XLEN-1:0] uie_q, uie_d;
    logic [XLEN-1:0] utvec_q, utvec_d;
    logic [XLEN-1:0] uscratch_q, uscratch_d;
    logic [XLEN-1:0] uepc_q, uepc_d;
    logic [XLEN-1:0] ucause_q, ucause_d;
    logic [XLEN-1:0] utval_q, utval_d;
    logic [XLEN-1:0] uip_q, uip_d;
    logic [63:0]     cycle_q, cycle_d;
    logic [63:0]     time_q, time_d;
    logic [63:0]     instret_q, instret_d;
    logic [PW-1:0]   presc_q, presc_d;

    csr_op_e         op;
    csr_rd_t         acc, disp;
    logic            wr_attempt, illegal, csr_we;
    logic [XLEN-1:0] new_val, pend, base;

    function automatic csr_rd_t csr_lookup(input logic [11:0] addr);
        csr_rd_t r;
        r     = '0;
        r.hit = 1'b1;
        case (addr)
            12'h000: r.data = XLEN'({upie_q, 3'b000, uie_bit_q});
            12'h001: r.data = XLEN'(fflags_q);
            12'h002: r.data = XLEN'(frm_q);
            12'h003: r.data = XLEN'({frm_q, fflags_q});
            12'h004: r.data = uie_q;
            12'h005: r.data = utvec_q;
            12'h040: r.data = uscratch_q;
            12'h041: r.data = uepc_q;
            12'h042: r.data = ucause_q;
            12'h043: r.data = utval_q;
            12'h044: r.data = uip_q;
            12'hC00: begin r.ro = 1'b1; r.data = XLEN'(cycle_q);           end
            12'hC01: begin r.ro = 1'b1; r.data = XLEN'(time_q);            end
            12'hC02: begin r.ro = 1'b1; r.data = XLEN'(instret_q);         end
            12'hC80: begin r.ro = 1'b1; r.data = XLEN'(cycle_q >> XLEN);   end
            12'hC81: begin r.ro = 1'b1; r.data = XLEN'(time_q >> XLEN);    end
            12'hC82: begin r.ro = 1'b1; r.data = XLEN'(instret_q >> XLEN); end
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

    assign op = csr_op_e'(iCsrOp);

    always_comb begin
        acc        = csr_lookup(iCsrAddr);
        disp       = csr_lookup(iDispSelect);
        wr_attempt = (op == CSR_RW) || ((op != CSR_NONE) && !iNoWrite);
        illegal    = (op != CSR_NONE) && (!acc.hit || (wr_attempt && acc.ro));
        // A trap on the same edge swallows the write but the fault is still reported.
        csr_we     = (op != CSR_NONE) && wr_attempt && !illegal && !iTrap;
        case (op)
            CSR_RW:  new_val = iWriteData;
            CSR_RS:  new_val = acc.data | iWriteData;
            CSR_RC:  new_val = acc.data & ~iWriteData;
            default: new_val = acc.data;
        endcase
    end

    assign oReadData = acc.data;
    assign oIllegal  = illegal;
    assign oDispData = disp.data;
    assign oEpc      = uepc_q;

    always_comb begin
        base    = {utvec_q[XLEN-1:2], 2'b00};
        oTrapPC = base;
        if (utvec_q[1:0] == 2'b01 && iCause[XLEN-1])
            oTrapPC = base + {iCause[XLEN-3:0], 2'b00};
    end

    always_comb begin
        pend      = uip_q & uie_q;
        oIrqReq   = uie_bit_q && (|pend);
        oIrqCause = '0;
        if (oIrqReq) begin
            if (pend[8])      oIrqCause = IRQ_FLAG | XLEN'(8);
            else if (pend[0]) oIrqCause = IRQ_FLAG;
            else              oIrqCause = IRQ_FLAG | XLEN'(4);
        end
    end

    always_comb begin
        uie_bit_d  = uie_bit_q;
        upie_d     = upie_q;
        fflags_d   = fflags_q;
        frm_d      = frm_q;
        uie_d      = uie_q;
        utvec_d    = utvec_q;
        uscratch_d = uscratch_q;
        uepc_d     = uepc_q;
        ucause_d   = ucause_q;
        utval_d    = utval_q;
        uip_d      = XLEN'({iIrqExt, 3'b000, iIrqTimer, 3'b000, iIrqSoft});
        cycle_d    = cycle_q + 64'd1;
        instret_d  = iRetire ? instret_q + 64'd1 : instret_q;
        time_d     = time_q;
        presc_d    = presc_q + PW'(1);
        if (presc_q == PW'(TIME_DIV - 1)) begin
            presc_d = '0;
            time_d  = time_q + 64'd1;
        end

        if (iTrap) begin
            uepc_d    = iEpc & EPC_MASK;
            ucause_d  = iCause;
            utval_d   = iTval;
            upie_d    = uie_bit_q;
            uie_bit_d = 1'b0;
        end else begin
            if (iUret) begin
                uie_bit_d = upie_q;
                upie_d    = 1'b1;
            end
            // URET owns ustatus on its edge; writes elsewhere still land.
            if (csr_we) begin
                case (iCsrAddr)
                    12'h000: if (!iUret) begin
                        uie_bit_d = new_val[0];
                        upie_d    = new_val[4];
                    end
                    12'h001: fflags_d   = new_val[4:0];
                    12'h002: frm_d      = new_val[2:0];
                    12'h003: begin
                        frm_d    = new_val[7:5];
                        fflags_d = new_val[4:0];
                    end
                    12'h004: uie_d      = new_val & UIE_MASK;
                    12'h005: utvec_d    = new_val;
                    12'h040: uscratch_d = new_val;
                    12'h041: uepc_d     = new_val & EPC_MASK;
                    12'h042: ucause_d   = new_val;
                    12'h043: utval_d    = new_val;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            uie_bit_q  <= 1'b0;
            upie_q     <= 1'b0;
            fflags_q   <= '0;
            frm_q      <= '0;
            uie_q      <= '0;
            utvec_q    <= UTVEC_RESET;
            uscratch_q <= '0;
            uepc_q     <= '0;
            ucause_q   <= '0;
            utval_q    <= '0;
            uip_q      <= '0;
            cycle_q    <= '0;
            time_q     <= '0;
            instret_q  <= '0;
            presc_q    <= '0;
        end else begin
            uie_bit_q  <= uie_bit_d;
            upie_q     <= upie_d;
            fflags_q   <= fflags_d;
            frm_q      <= frm_d;
            uie_q      <= uie_d;
            utvec_q    <= utvec_d;
            uscratch_q <= uscratch_d;
            uepc_q     <= uepc_d;
            ucause_q   <= ucause_d;
            utval_q    <= utval_d;
            uip_q      <= uip_d;
            cycle_q    <= cycle_d;
            time_q     <= time_d;
            instret_q  <= instret_d;
            presc_q    <= presc_d;
        end
    end

endmodule
